// File: rtl/lsu_pipe_mem.sv
// Load/store unit between EXU and WBU: one bus transaction per memory instruction,
// lane steering and load extension. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_pipe_mem #(
    parameter int XLEN = 64,
    parameter int AW   = 32,
    parameter int RFAW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_pass,
    input  logic [RFAW-1:0]   in_rd,
    input  logic              in_rf_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RFAW-1:0]   out_rd,
    output logic              out_rf_we,
    output logic [XLEN-1:0]   out_wdata,
    output logic              out_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [AW-1:0]     mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // a producer holding valid keeps its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;
    state_t state, state_next;

    logic              load_q, store_q, uns_q, rf_we_q;
    logic [1:0]        size_q;
    logic [XLEN-1:0]   addr_q, wdata_q, out_wdata_q;
    logic [RFAW-1:0]   out_rd_q;
    logic              out_rf_we_q;
    logic              accept, mem_op_in, trap_in;
    logic [OFFW-1:0]   off;
    logic [1:0]        esz;
    logic [NB-1:0]     base_mask;
    logic [XLEN-1:0]   low_mask, shifted, load_ext;
    logic              sign;

    // A 32-bit datapath has no doubleword, so size 3 collapses to a word.
    function automatic logic [1:0] eff_size(input logic [1:0] s);
        if (XLEN == 32 && s == 2'd3) return 2'd2;
        return s;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    function automatic logic misaligned(input logic [OFFW-1:0] a, input logic [1:0] s);
        logic m;
        m = 1'b0;
        for (int i = 0; i < OFFW; i++)
            if (i < int'(eff_size(s)) && a[i]) m = 1'b1;
        return m;
    endfunction

    assign trap_in      = mem_op_in & misaligned(in_addr[OFFW-1:0], in_size);
    assign out_misalign = misalign_q;
`else
    assign trap_in      = 1'b0;
    assign out_misalign = 1'b0;
`endif

    assign mem_op_in = in_load | in_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = RESP;
            end
            RESP: if (mem_resp_valid) state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            if (mem_op_in && !trap_in) state_next = REQ;
            else                       state_next = OUT;
        end
    end

    // Lane steering from the latched address; bytes past the lane fall off the shift.
    always_comb begin
        off  = addr_q[OFFW-1:0];
        esz  = eff_size(size_q);
        base_mask = '0;
        for (int i = 0; i < NB; i++)
            base_mask[i] = (i < (1 << esz));
        low_mask = '0;
        for (int i = 0; i < XLEN; i++)
            low_mask[i] = (i < (8 << esz));
        shifted = mem_resp_rdata >> {off, 3'b000};
        case (esz)
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = shifted[XLEN-1];
        endcase
        load_ext = (shifted & low_mask) | ((sign && !uns_q) ? ~low_mask : '0);
    end

    assign mem_req_we    = mem_req_valid & store_q;
    assign mem_req_addr  = mem_req_valid ? AW'(addr_q & ~XLEN'(NB - 1)) : '0;
    assign mem_req_wmask = mem_req_valid ? (base_mask << off) : '0;
    assign mem_req_wdata = mem_req_valid ? (wdata_q << {off, 3'b000}) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            rf_we_q     <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_rd_q    <= '0;
            out_rf_we_q <= 1'b0;
            out_wdata_q <= '0;
        end else if (accept) begin
            load_q   <= in_load & ~in_store;
            store_q  <= in_store;
            uns_q    <= in_unsigned;
            rf_we_q  <= in_rf_we;
            size_q   <= in_size;
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            out_rd_q <= in_rd;
            if (!mem_op_in) begin
                out_wdata_q <= in_pass;
                out_rf_we_q <= in_rf_we;
            end else if (trap_in) begin
                out_wdata_q <= in_addr;
                out_rf_we_q <= 1'b0;
            end
        end else if (state == RESP && mem_resp_valid) begin
            out_wdata_q <= load_q ? load_ext : '0;
            out_rf_we_q <= load_q & rf_we_q;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         misalign_q <= 1'b0;
        else if (accept) misalign_q <= trap_in;
    end
`endif

    assign out_rd    = out_rd_q;
    assign out_rf_we = out_rf_we_q;
    assign out_wdata = out_wdata_q;
endmodule
